// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request front-end: FSM states, default widths, request struct.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_ctrl_pkg;

    localparam int MEM_CTRL_ADDR_WIDTH = 4;
    localparam int MEM_CTRL_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3,
        SCRUB   = 3'd4
    } mem_ctrl_state_e;

    // Request as seen on the request channel, at the default widths.
    typedef struct packed {
        logic                           we;
        logic [MEM_CTRL_ADDR_WIDTH-1:0] addr;
        logic [MEM_CTRL_DATA_WIDTH-1:0] wdata;
    } mem_ctrl_req_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request front-end for a single-port memory; optional power-up zero sweep under MEM_CTRL_SCRUB_EN.
// Latency: read accept N -> mem_rd_en N+1 -> rsp_valid N+3; write accept N -> mem_wr_en N+1, next accept N+2.
// Backpressure: req_ready only in IDLE; rsp_valid/rsp_rdata held while rsp_ready is low, blocking new requests.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_CTRL_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_CTRL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  init_done
);

    // Latched request; its addr/wdata fields drive the memory pins directly,
    // so they hold their last value whenever the enables are low.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

`ifdef MEM_CTRL_SCRUB_EN
    localparam mem_ctrl_state_e RESET_STATE = SCRUB;
`else
    localparam mem_ctrl_state_e RESET_STATE = IDLE;
`endif

    mem_ctrl_state_e       r_state;
    mem_ctrl_state_e       w_state_nxt;
    req_t                  r_req;
    req_t                  w_req_nxt;
    logic                  r_mem_rd_en;
    logic                  r_mem_wr_en;
    logic                  w_mem_rd_en_nxt;
    logic                  w_mem_wr_en_nxt;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_init_done;
    logic                  w_req_ready;

`ifdef MEM_CTRL_SCRUB_EN
    logic [ADDR_WIDTH-1:0] r_scrub_cnt;
    logic                  r_init_done;

    // Sweep address counter; restarts at 0 on every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scrub_cnt <= '0;
        end else if (r_state == SCRUB) begin
            r_scrub_cnt <= r_scrub_cnt + 1'b1;
        end
    end

    // Operational once the FSM has left SCRUB (first IDLE cycle carries the last write).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_done <= 1'b0;
        end else if (r_state == IDLE) begin
            r_init_done <= 1'b1;
        end
    end

    assign w_init_done = r_init_done;
`else
    assign w_init_done = 1'b1;
`endif

    // Pure state decode: no combinational path from req_valid.
    assign w_req_ready = (r_state == IDLE) && w_init_done;

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_mem_rd_en_nxt = 1'b0;
        w_mem_wr_en_nxt = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        case (r_state)
            IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_req_nxt.we   = req_we;
                    w_req_nxt.addr = req_addr;
                    if (req_we) begin
                        w_req_nxt.wdata = req_wdata;
                    end
                    w_mem_wr_en_nxt = req_we;
                    w_mem_rd_en_nxt = !req_we;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = r_req.we ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = mem_rdata;
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
`ifdef MEM_CTRL_SCRUB_EN
            SCRUB: begin
                w_req_nxt.we    = 1'b1;
                w_req_nxt.addr  = r_scrub_cnt;
                w_req_nxt.wdata = '0;
                w_mem_wr_en_nxt = 1'b1;
                if (r_scrub_cnt == '1) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, request latch, memory pins and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_req       <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_mem_rd_en <= w_mem_rd_en_nxt;
            r_mem_wr_en <= w_mem_wr_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_wr_en = r_mem_wr_en;
    assign init_done = w_init_done;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port memory behind it.
// Latency: checks exact cycle positions of enables and responses.
// Backpressure: exercises rsp_ready stalls and req_valid held while busy.
module tb_mem_req_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic [3:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        init_done;

    int n_chk  = 0;
    int n_pass = 0;
    int n_en   = 0;
    int n_both = 0;
    int n_hs   = 0;
    int n_vcyc = 0;

    logic        preload = 1'b1;
    logic [15:0] mem [16];

    mem_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Single-port memory: synchronous write, read data one cycle after rd_en.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
        end
    end

    // Activity counters sampled mid-cycle.
    always @(negedge clk) begin
        n_en = n_en + int'(mem_wr_en) + int'(mem_rd_en);
        if (mem_wr_en && mem_rd_en) n_both = n_both + 1;
        if (rsp_valid && rsp_ready) n_hs = n_hs + 1;
        if (rsp_valid) n_vcyc = n_vcyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send(input mem_ctrl_req_t r);
        int t;
        req_valid = 1'b1;
        req_we    = r.we;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        t = 0;
        while (!req_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid at a negedge and returns the data; handshake at the next edge.
    task automatic wait_rsp(output logic [15:0] d);
        int t;
        t = 0;
        while (!rsp_valid && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) chk("rsp_timeout", 32'd0, 32'd1);
        d = rsp_rdata;
        @(negedge clk);
    endtask

    // Called at the negedge after reset is released; waits until the controller is usable.
    task automatic wait_init(input string tag);
`ifdef MEM_CTRL_SCRUB_EN
        int t;
        int nwr;
        int bad;
        t = 0; nwr = 0; bad = 0;
        while (!init_done && t < 64) begin
            if (mem_wr_en) begin
                if (mem_wdata !== 16'h0 || mem_addr !== 4'(nwr)) bad++;
                nwr++;
            end
            if (req_ready) bad++;
            @(negedge clk);
            t++;
        end
        chk({tag, "_scrub_writes"}, 32'(nwr), 32'd16);
        chk({tag, "_scrub_bad"}, 32'(bad), 32'd0);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
`else
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
`endif
    endtask

    initial begin
        logic [15:0] d;
        int en0;
        int hs0;
        int v0;

        // Reset and reset values
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        wait_init("init");

        // Write 3 = A5A5, then read it back
        send('{we: 1'b1, addr: 4'd3, wdata: 16'hA5A5});
        chk("wr_en_n1", {31'd0, mem_wr_en}, 32'd1);
        chk("wr_rd_en_n1", {31'd0, mem_rd_en}, 32'd0);
        chk("wr_addr_n1", {28'd0, mem_addr}, 32'd3);
        chk("wr_wdata_n1", {16'd0, mem_wdata}, 32'hA5A5);
        chk("wr_ready_n1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wr_ready_n2", {31'd0, req_ready}, 32'd1);
        chk("wr_en_n2", {31'd0, mem_wr_en}, 32'd0);
        send('{we: 1'b0, addr: 4'd3, wdata: 16'h0});
        chk("rd_en_n1", {31'd0, mem_rd_en}, 32'd1);
        chk("rd_wr_en_n1", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        chk("rd_vld_n2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_vld_n3", {31'd0, rsp_valid}, 32'd1);
        chk("rd_data_n3", {16'd0, rsp_rdata}, 32'hA5A5);
        @(negedge clk);
        chk("rd_vld_n4", {31'd0, rsp_valid}, 32'd0);
        chk("rd_ready_n4", {31'd0, req_ready}, 32'd1);

        // Read 7 with consumer stalled for 5 cycles
        rsp_ready = 1'b0;
        hs0 = n_hs;
        send('{we: 1'b0, addr: 4'd7, wdata: 16'h0});
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_vld_%0d", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("stall_data_%0d", i), {16'd0, rsp_rdata}, 32'h1007);
            chk($sformatf("stall_ready_%0d", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_vld_after", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("stall_rsp_count", 32'(n_hs - hs0), 32'd1);

        // Back-to-back writes of all addresses, then in-order reads
        for (int a = 0; a < 16; a++) send('{we: 1'b1, addr: 4'(a), wdata: 16'(a) * 16'h0101});
        for (int a = 0; a < 16; a++) begin
            send('{we: 1'b0, addr: 4'(a), wdata: 16'h0});
            wait_rsp(d);
            chk($sformatf("sweep_rd_%0d", a), {16'd0, d}, {16'd0, 16'(a) * 16'h0101});
        end

        // Reset during ISSUE of a read: response discarded
        v0 = n_vcyc;
        send('{we: 1'b0, addr: 4'd5, wdata: 16'h0});
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("midrst_vld", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        wait_init("midrst");
        repeat (8) @(negedge clk);
        chk("midrst_no_rsp", 32'(n_vcyc - v0), 32'd0);

        // Request held while busy in RESP: accepted only after handshake
        rsp_ready = 1'b0;
        hs0 = n_hs;
        en0 = n_en;
        send('{we: 1'b0, addr: 4'd2, wdata: 16'h0});
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_ready_%0d", i), {31'd0, req_ready}, 32'd0);
            chk($sformatf("busy_wr_en_%0d", i), {31'd0, mem_wr_en}, 32'd0);
            @(negedge clk);
        end
        chk("busy_rdata", {16'd0, rsp_rdata}, 32'h0202);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("busy_ready_after_hs", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("busy_wr_addr", {28'd0, mem_addr}, 32'd9);
        repeat (3) @(negedge clk);
        chk("busy_enables", 32'(n_en - en0), 32'd2);
        chk("busy_rsp_count", 32'(n_hs - hs0), 32'd1);
        send('{we: 1'b0, addr: 4'd9, wdata: 16'h0});
        wait_rsp(d);
        chk("busy_rd9", {16'd0, d}, 32'hBEEF);

        // Final reset then read 9: scrub zeroes it, otherwise memory retains BEEF
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wait_init("final");
        send('{we: 1'b0, addr: 4'd9, wdata: 16'h0});
        wait_rsp(d);
`ifdef MEM_CTRL_SCRUB_EN
        chk("final_rd9", {16'd0, d}, 32'h0000);
`else
        chk("final_rd9", {16'd0, d}, 32'hBEEF);
`endif
        chk("never_both_en", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
